// File: rtl/mod_counter_pkg.sv
// Shared definitions for the counter family.
// Provides the default modulus/width, the direction encoding (UP=1, DOWN=0)
// and the run/oneshot-complete state encoding used by counter blocks.
package mod_counter_pkg;

    localparam int unsigned DEF_N = 10;
    localparam int unsigned DEF_W = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } run_state_e;

endpackage

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous load, free-running or oneshot
// mode, terminal-count carry for cascading, and a registered wrap pulse.
//
// Ports:
//   clk      : clock, all state changes on rising edge
//   rst      : synchronous active-high reset (out=0, wrap=0, done=0)
//   en       : count enable, one step per enabled cycle
//   dir      : direction, 1 = up, 0 = down
//   load     : synchronous load strobe, wins over en
//   load_val : value to load, clamped to N-1
//   oneshot  : 1 = stop at terminal value and set done, 0 = wrap
//   out      : registered count, always in 0..N-1
//   tc       : combinational carry: en & ~done & (out == terminal value)
//   wrap     : one-cycle pulse the cycle after a wrap
//   done     : registered oneshot-complete flag
module mod_n_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         oneshot,
    output logic [W-1:0] out,
    output logic         tc,
    output logic         wrap,
    output logic         done
);

    localparam logic [W-1:0] MAX_VAL = W'(N - 1);
    // One extra bit so load_val can be compared against N even when N == 2**W.
    localparam logic [W:0]   N_EXT   = (W + 1)'(N);

    logic [W-1:0] out_q, out_d;
    logic         wrap_q, wrap_d;
    run_state_e   state_q, state_d;

    dir_e         dir_s;
    logic [W-1:0] term_val;
    logic         at_term;
    logic [W-1:0] load_clamped;
    logic [W-1:0] step_val;

    always_comb begin
        dir_s        = dir_e'(dir);
        term_val     = (dir_s == DIR_UP) ? MAX_VAL : '0;
        at_term      = (out_q == term_val);
        load_clamped = ({1'b0, load_val} >= N_EXT) ? MAX_VAL : load_val;

        // Stepping from the terminal value wraps to the opposite end.
        if (dir_s == DIR_UP) begin
            step_val = at_term ? '0 : out_q + W'(1);
        end else begin
            step_val = at_term ? MAX_VAL : out_q - W'(1);
        end
    end

    always_comb begin
        out_d   = out_q;
        wrap_d  = 1'b0;
        state_d = state_q;

        if (load) begin
            out_d   = load_clamped;
            state_d = ST_RUN;
        end else if (en && (state_q == ST_RUN)) begin
            if (at_term && oneshot) begin
                // Oneshot completion: hold the terminal value, no wrap.
                state_d = ST_DONE;
            end else begin
                out_d  = step_val;
                wrap_d = at_term;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            wrap_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign done = (state_q == ST_DONE);
    // Carry is combinational on en so a chain of stages steps on the same edge.
    assign tc   = en & (state_q == ST_RUN) & at_term;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
module tb_mod_n_updown_counter;

    localparam int N = 10;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT
    logic         rst = 1'b1, en = 1'b0, dir = 1'b1, load = 1'b0, oneshot = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         tc, wrap, done;

    // Two-digit cascade
    logic         c_rst = 1'b1, c_en0 = 1'b0;
    logic [W-1:0] c_out0, c_out1;
    logic         c_tc0, c_tc1, c_wrap0, c_wrap1, c_done0, c_done1;

    mod_n_updown_counter #(.N(N), .W(W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .oneshot(oneshot),
        .out(out), .tc(tc), .wrap(wrap), .done(done)
    );

    mod_n_updown_counter #(.N(N), .W(W)) u_c0 (
        .clk(clk), .rst(c_rst), .en(c_en0), .dir(1'b1), .load(1'b0),
        .load_val(4'd0), .oneshot(1'b0),
        .out(c_out0), .tc(c_tc0), .wrap(c_wrap0), .done(c_done0)
    );

    mod_n_updown_counter #(.N(N), .W(W)) u_c1 (
        .clk(clk), .rst(c_rst), .en(c_tc0), .dir(1'b1), .load(1'b0),
        .load_val(4'd0), .oneshot(1'b0),
        .out(c_out1), .tc(c_tc1), .wrap(c_wrap1), .done(c_done1)
    );

    typedef struct {
        bit chk;
        bit is_cas;
        int out;
        bit wrap;
        bit done;
        bit tc;
        int out1;
        bit wrap1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of the main DUT: count as an integer, arithmetic mod N.
    int m_cnt = 0;
    bit m_wrap = 0, m_done = 0, m_known = 0;

    // Reference model of the cascade: a single decimal value 0..99.
    int c_val = 0;
    bit cw0 = 0, cw1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: the DUT presents a result every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                if (!mon_e.is_cas) begin
                    check("out",  32'(out),  32'(mon_e.out));
                    check("wrap", 32'(wrap), 32'(mon_e.wrap));
                    check("done", 32'(done), 32'(mon_e.done));
                    check("tc",   32'(tc),   32'(mon_e.tc));
                end else begin
                    check("cas_out0",  32'(c_out0),  32'(mon_e.out));
                    check("cas_out1",  32'(c_out1),  32'(mon_e.out1));
                    check("cas_wrap0", 32'(c_wrap0), 32'(mon_e.wrap));
                    check("cas_wrap1", 32'(c_wrap1), 32'(mon_e.wrap1));
                    check("cas_tc0",   32'(c_tc0),   32'(mon_e.tc));
                end
            end
        end
    end

    task automatic drive(input bit r, input bit l, input int lv, input bit e, input bit d, input bit o);
        exp_t x;
        int   term;
        int   lvc;
        @(posedge clk);
        #1;
        rst = r; load = l; load_val = W'(lv); en = e; dir = d; oneshot = o;
        term   = d ? N - 1 : 0;
        x.chk  = m_known;
        x.is_cas = 1'b0;
        x.out  = m_cnt;
        x.wrap = m_wrap;
        x.done = m_done;
        x.tc   = e && !m_done && (m_cnt == term);
        x.out1 = 0;
        x.wrap1 = 1'b0;
        sb.push_back(x);
        if (r) begin
            m_cnt = 0; m_wrap = 0; m_done = 0; m_known = 1;
        end else if (l) begin
            lvc   = lv % 16;
            m_cnt = (lvc > N - 1) ? N - 1 : lvc;
            m_wrap = 0; m_done = 0;
        end else if (e && !m_done) begin
            if (m_cnt == term && o) begin
                m_done = 1; m_wrap = 0;
            end else begin
                m_wrap = (m_cnt == term);
                m_cnt  = d ? (m_cnt + 1) % N : (m_cnt + N - 1) % N;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic drive_cas(input bit r, input bit e0);
        exp_t x;
        @(posedge clk);
        #1;
        c_rst = r; c_en0 = e0;
        x.chk    = 1'b1;
        x.is_cas = 1'b1;
        x.out    = c_val % 10;
        x.out1   = c_val / 10;
        x.wrap   = cw0;
        x.wrap1  = cw1;
        x.tc     = e0 && (c_val % 10 == 9);
        x.done   = 1'b0;
        sb.push_back(x);
        if (r) begin
            c_val = 0; cw0 = 0; cw1 = 0;
        end else if (e0) begin
            cw0   = (c_val % 10 == 9);
            cw1   = (c_val == 99);
            c_val = (c_val + 1) % 100;
        end else begin
            cw0 = 0; cw1 = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then count up through a wrap
        repeat (5) drive(1, 0, 0, 0, 1, 0);
        repeat (12) drive(0, 0, 0, 1, 1, 0);

        // Load 3, count down through 0 -> 9; then clamped load
        drive(0, 1, 3, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 12, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 15, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Oneshot up from 7; clearing oneshot keeps done; load 0 clears it
        drive(0, 1, 7, 0, 1, 1);
        repeat (5) drive(0, 0, 0, 1, 1, 1);
        repeat (2) drive(0, 0, 0, 1, 1, 0);
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        // Oneshot down stops at 0
        drive(0, 1, 2, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 1, 0, 1);

        // Direction toggling every cycle from 5; load with en high
        drive(0, 1, 5, 0, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 2, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        // Reversal at terminal value steps normally
        drive(0, 1, 9, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 1, 0, 0);

        // Reset mid-count at 6, and while done
        drive(0, 1, 0, 0, 1, 0);
        repeat (6) drive(0, 0, 0, 1, 1, 0);
        drive(1, 1, 4, 1, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 1, 0);
        drive(0, 1, 9, 0, 1, 1);
        repeat (2) drive(0, 0, 0, 1, 1, 1);
        drive(1, 0, 0, 1, 1, 1);
        repeat (3) drive(0, 0, 0, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end

        // Two-digit cascade: 100 steps reach 99 then roll to 00
        repeat (2) drive_cas(1, 0);
        repeat (102) drive_cas(0, 1);
        for (int i = 0; i < 60; i++) begin
            drive_cas(0, ($urandom_range(0, 3) != 0));
        end
        drive_cas(0, 0);

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter N, default 10: modulus; count range 0..N-1; N >= 2.
REQ-002 Parameter W, default 4: count width; W >= ceil(log2(N)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; counter advances one step per enabled cycle.
REQ-006 dir  input  1  direction; 1 = up, 0 = down; sampled every cycle.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  W  value loaded when load=1.
REQ-009 oneshot  input  1  mode; 0 = free-running wrap, 1 = stop at terminal value.
REQ-010 out  output  W  current count, registered.
REQ-011 tc  output  1  terminal-count carry, combinational: en & ~done & (out == terminal value for current dir).
REQ-012 wrap  output  1  registered one-cycle pulse, high the cycle after a wrap occurred.
REQ-013 done  output  1  registered oneshot-complete flag.

Function
REQ-014 Priority per edge SHALL be rst > load > en; dir and oneshot SHALL be used only when en=1 and load=0.
REQ-015 Terminal value SHALL be N-1 when dir=1 and 0 when dir=0.
REQ-016 Up step: out SHALL become out+1, or 0 when out == N-1.
REQ-017 Down step: out SHALL become out-1, or N-1 when out == 0.
REQ-018 A step from the terminal value in free-running mode SHALL be a wrap; wrap SHALL be 1 in the following cycle only.
REQ-019 In oneshot mode, an enabled step at the terminal value SHALL hold out unchanged, set done=1, and produce no wrap.
REQ-020 While done=1, en SHALL have no effect on out; tc SHALL be 0.
REQ-021 load SHALL set out to load_val, clear done, and clear wrap next cycle; load_val >= N SHALL be clamped to N-1.
REQ-022 load and en both high SHALL load only; no step in that cycle.
REQ-023 dir change SHALL take effect on the same edge; no dead cycle; direction reversal at a terminal value SHALL step normally (e.g. out=N-1, dir=0 -> N-2).
REQ-024 Clearing oneshot while done=1 SHALL leave done=1 until load or rst.
REQ-025 en=0 SHALL hold out, done; wrap SHALL drop to 0.
REQ-026 Arithmetic SHALL be modulo N at width W; out SHALL never exceed N-1 after any edge.
REQ-027 Cascading: tc of stage k driving en of stage k+1 SHALL form a correct multi-digit counter, with no extra latency.

Reset
REQ-028 rst=1 SHALL set out=0, wrap=0, done=0 on the next rising edge, overriding load and en.
REQ-029 rst asserted mid-count or mid-oneshot SHALL abort the operation; counting SHALL resume from 0 on the first cycle with rst=0 and en=1.
REQ-030 No asynchronous reset path.

Structure
REQ-031 Default N, W and the direction encoding (UP=1, DOWN=0) SHALL live in a shared package/header mod_counter_pkg, reused by other counter blocks.
REQ-032 Single module; no sub-module; next-state logic and output registers in one block, estimated 120-200 lines.

Verification (N=10, W=4)
REQ-033 rst 5 cycles, then dir=1, en=1 for 12 cycles -> out 0,1..9,0,1; wrap=1 exactly the cycle after 9->0; tc=1 only while out=9.
REQ-034 load=1, load_val=3, then dir=0, en=1 -> out 3,2,1,0,9; wrap pulse after 0->9; load_val=12 -> out=9.
REQ-035 oneshot=1, dir=1, load 7, en=1 for 5 cycles -> out 7,8,9,9,9; done=1 from the cycle after the step at 9; no wrap; then load 0 -> done=0.
REQ-036 out=5, en=1, toggle dir every cycle -> out 6,5,6,5; load and en both high -> load value, no step.
REQ-037 Two instances cascaded (tc0 -> en1), en0=1 for 100 cycles -> {out1,out0} reaches 9,9 at cycle 99, then 0,0; wrap on both stages.
REQ-038 rst asserted while out=6 and while done=1 -> out=0, done=0, wrap=0 next edge; count restarts 0,1,2.
